id_issue_ctrl: RTL and testbench

//  Issue controller for the ID stage. Tracks destination registers of in-flight long-latency ops
//  (loads, multi-cycle ALU) in a 32-entry scoreboard and stalls ID on RAW/WAW hazards.

---
 rtl/id_issue_ctrl_pkg.sv | 5 +
 rtl/id_issue_ctrl_if.sv | 27 ++
 rtl/id_issue_ctrl_scoreboard.sv | 32 +++
 rtl/id_issue_ctrl.sv | 88 ++++++++
 tb/tb_id_issue_ctrl.sv | 122 ++++++++++++
 5 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// id_issue_ctrl_pkg: shared state encodings and constants for the ID issue controller
package id_issue_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HOLD} state_e;
  localparam logic [4:0] REG_ZERO = 5'h0;
endpackage

// File: rtl/id_issue_ctrl_if.sv
// id_issue_ctrl_if: ID decode, write-back and pipeline control signals of the issue controller
interface id_issue_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  reg1_raddr_i;
  logic [4:0]  reg2_raddr_i;
  logic [4:0]  reg_waddr_i;
  logic        long_op_i;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic        jump_i;
  logic        hold_i;
  logic        issue_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] busy_o;
  logic        err_o;
  modport master (
    output id_valid_i, reg1_raddr_i, reg2_raddr_i, reg_waddr_i, long_op_i,
    output wb_valid_i, wb_addr_i, jump_i, hold_i,
    input  issue_o, stall_o, flush_o, busy_o, err_o
  );
  modport slave (
    input  id_valid_i, reg1_raddr_i, reg2_raddr_i, reg_waddr_i, long_op_i,
    input  wb_valid_i, wb_addr_i, jump_i, hold_i,
    output issue_o, stall_o, flush_o, busy_o, err_o
  );
endinterface

// File: rtl/id_issue_ctrl_scoreboard.sv
// id_scoreboard: per-register pending-write bits with RAW/WAW lookups
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en_i,
  input  logic [4:0]  set_addr_i,
  input  logic        clr_en_i,
  input  logic [4:0]  clr_addr_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  output logic        raw_o,
  output logic        waw_o,
  output logic [31:0] busy_o
);
  logic [31:0] busy_q, busy_d, set_m, clr_m;
  // set is applied after clear so a same-register set wins; x0 is never busy
  always_comb begin
    set_m  = set_en_i ? 32'(1) << set_addr_i : '0;
    clr_m  = clr_en_i ? 32'(1) << clr_addr_i : '0;
    busy_d = ((busy_q & ~clr_m) | set_m) & ~32'(1);
  end
  // busy vector register
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  assign raw_o  = (busy_q[rs1_i] && rs1_i != REG_ZERO) || (busy_q[rs2_i] && rs2_i != REG_ZERO);
  assign waw_o  = busy_q[rd_i] && rd_i != REG_ZERO;
  assign busy_o = busy_q;
endmodule

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: ID-stage issue control with hazard scoreboard, jump flush and hold freeze
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_PENDING  = 4
) (
  input logic           clk,
  input logic           rst,
  id_issue_ctrl_if.slave bus
);
  // a jump seen in RUN/FLUSH flushes combinationally that cycle, so FLUSH covers the remainder
  localparam bit         JUMP_TO_FLUSH = FLUSH_CYCLES > 1;
  localparam logic [3:0] CNT_JUMP      = JUMP_TO_FLUSH ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [3:0] CNT_HOLD      = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] PEND_MAX      = 4'(MAX_PENDING);
  state_e     state_q, state_d, exit_st;
  logic [3:0] cnt_q, cnt_d, pend_q, pend_d;
  logic       err_q, err_d, raw, waw, full, issue, inc;
  assign exit_st = bus.hold_i ? ST_HOLD : ST_RUN;
  assign full    = bus.long_op_i && pend_q == PEND_MAX;
  assign issue   = rst && state_q == ST_RUN && !bus.jump_i && !bus.hold_i && bus.id_valid_i
                   && !raw && !waw && !full;
  assign inc     = issue && bus.long_op_i;
  assign bus.issue_o = issue;
  assign bus.stall_o = rst && (state_q == ST_HOLD
                       || (state_q == ST_RUN && bus.id_valid_i && !issue && !bus.jump_i));
  assign bus.flush_o = rst && (state_q == ST_FLUSH || (state_q == ST_RUN && bus.jump_i));
  assign bus.err_o   = err_q;
  // next state and flush countdown; jump outranks hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN:
        if (bus.jump_i) begin
          state_d = JUMP_TO_FLUSH ? ST_FLUSH : exit_st;
          cnt_d   = CNT_JUMP;
        end else if (bus.hold_i) state_d = ST_HOLD;
      ST_FLUSH:
        if (bus.jump_i) begin
          state_d = JUMP_TO_FLUSH ? ST_FLUSH : exit_st;
          cnt_d   = CNT_JUMP;
        end else if (cnt_q == 4'd0) state_d = exit_st;
        else cnt_d = cnt_q - 4'd1;
      ST_HOLD:
        if (bus.jump_i) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_HOLD;
        end else if (!bus.hold_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end
  // outstanding long-op count saturates both ways; a stray write-back latches the error
  always_comb begin
    pend_d = inc == bus.wb_valid_i ? pend_q
           : inc ? (pend_q == 4'hF ? pend_q : pend_q + 4'd1)
           : (pend_q == 4'd0 ? pend_q : pend_q - 4'd1);
    err_d  = err_q || (bus.wb_valid_i && pend_q == 4'd0);
  end
  // control state registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  id_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (inc && bus.reg_waddr_i != REG_ZERO),
    .set_addr_i (bus.reg_waddr_i),
    .clr_en_i   (bus.wb_valid_i),
    .clr_addr_i (bus.wb_addr_i),
    .rs1_i      (bus.reg1_raddr_i),
    .rs2_i      (bus.reg2_raddr_i),
    .rd_i       (bus.reg_waddr_i),
    .raw_o      (raw),
    .waw_o      (waw),
    .busy_o     (bus.busy_o)
  );
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: directed vector table plus flush/hold/reset sequences for id_issue_ctrl
module tb_id_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  id_issue_ctrl_if bus ();
  id_issue_ctrl #(.FLUSH_CYCLES(2), .MAX_PENDING(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic v; logic [4:0] r1, r2, rd; logic lo, wv; logic [4:0] wa;
    logic ei, es; logic [31:0] eb; logic ee;
  } row_t;
  row_t rows[$];

  task automatic add(input logic v, input logic [4:0] r1, r2, rd, input logic lo, wv,
                     input logic [4:0] wa, input logic ei, es, input logic [31:0] eb, input logic ee);
    row_t r;
    r.v = v; r.r1 = r1; r.r2 = r2; r.rd = rd; r.lo = lo; r.wv = wv; r.wa = wa;
    r.ei = ei; r.es = es; r.eb = eb; r.ee = ee;
    rows.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, r2, rd, input logic lo, wv,
                       input logic [4:0] wa, input logic j, h);
    bus.id_valid_i = v; bus.reg1_raddr_i = r1; bus.reg2_raddr_i = r2; bus.reg_waddr_i = rd;
    bus.long_op_i = lo; bus.wb_valid_i = wv; bus.wb_addr_i = wa; bus.jump_i = j; bus.hold_i = h;
  endtask

  task automatic chk(input string nm, input logic ei, es, ef, ee, input logic [31:0] eb);
    checks++;
    if ({bus.issue_o, bus.stall_o, bus.flush_o, bus.err_o, bus.busy_o} !== {ei, es, ef, ee, eb}) begin
      failures++;
      $display("FAIL %s: got issue=%b stall=%b flush=%b err=%b busy=%h, want issue=%b stall=%b flush=%b err=%b busy=%h",
               nm, bus.issue_o, bus.stall_o, bus.flush_o, bus.err_o, bus.busy_o, ei, es, ef, ee, eb);
    end
  endtask

  task automatic jstep(input string nm, input logic j, h, ei, es, ef, input logic [31:0] eb);
    @(negedge clk);
    drive(1, 5'd1, 5'd0, 5'd2, 0, 0, 5'd0, j, h);
    #1 chk(nm, ei, es, ef, 1'b1, eb);
  endtask

  initial begin
    //   v r1 r2 rd lo wv wa  ei es busy      err
    add(1, 1, 2, 3, 0, 0, 0,  1, 0, 32'h0,    0);
    add(1, 0, 0, 5, 1, 0, 0,  1, 0, 32'h0,    0);
    add(1, 5, 0, 6, 0, 0, 0,  0, 1, 32'h20,   0);
    add(1, 5, 0, 6, 0, 1, 5,  0, 1, 32'h20,   0);
    add(1, 5, 0, 6, 0, 0, 0,  1, 0, 32'h0,    0);
    add(1, 0, 0, 0, 1, 0, 0,  1, 0, 32'h0,    0);
    add(1, 0, 0, 7, 0, 0, 0,  1, 0, 32'h0,    0);
    add(1, 0, 0, 8, 1, 0, 0,  1, 0, 32'h0,    0);
    add(1, 0, 0, 9, 1, 0, 0,  1, 0, 32'h100,  0);
    add(1, 0, 0, 10, 1, 0, 0, 1, 0, 32'h300,  0);
    add(1, 0, 0, 11, 1, 0, 0, 0, 1, 32'h700,  0);
    add(1, 1, 2, 12, 0, 0, 0, 1, 0, 32'h700,  0);
    add(1, 0, 0, 11, 1, 1, 8, 0, 1, 32'h700,  0);
    add(1, 0, 0, 11, 1, 0, 0, 1, 0, 32'h600,  0);
    add(1, 0, 0, 9, 0, 0, 0,  0, 1, 32'hE00,  0);
    add(0, 0, 0, 0, 0, 1, 9,  0, 0, 32'hE00,  0);
    add(0, 0, 0, 0, 0, 1, 10, 0, 0, 32'hC00,  0);
    add(0, 0, 0, 0, 0, 1, 11, 0, 0, 32'h800,  0);
    add(0, 0, 0, 0, 0, 1, 0,  0, 0, 32'h0,    0);
    add(0, 0, 0, 0, 0, 1, 3,  0, 0, 32'h0,    0);
    add(1, 0, 0, 1, 0, 0, 0,  1, 0, 32'h0,    1);
    add(1, 0, 0, 4, 1, 0, 0,  1, 0, 32'h0,    1);
    add(0, 0, 0, 0, 0, 1, 4,  0, 0, 32'h10,   1);
    add(1, 0, 0, 13, 1, 0, 0, 1, 0, 32'h0,    1);
    add(1, 0, 0, 14, 1, 1, 14, 1, 0, 32'h2000, 1);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h6000, 1);
    add(0, 0, 0, 0, 0, 1, 13, 0, 0, 32'h6000, 1);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h4000, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 chk("reset", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_reset_idle", 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      drive(rows[i].v, rows[i].r1, rows[i].r2, rows[i].rd, rows[i].lo, rows[i].wv, rows[i].wa, 0, 0);
      #1 chk($sformatf("row%0d", i), rows[i].ei, rows[i].es, 1'b0, rows[i].ee, rows[i].eb);
    end

    jstep("jump_a", 1, 0, 0, 0, 1, 32'h4000);
    jstep("jump_b", 0, 0, 0, 0, 1, 32'h4000);
    jstep("jump_done", 0, 0, 1, 0, 0, 32'h4000);
    jstep("rejump_a", 1, 0, 0, 0, 1, 32'h4000);
    jstep("rejump_b", 1, 0, 0, 0, 1, 32'h4000);
    jstep("rejump_c", 0, 0, 0, 0, 1, 32'h4000);
    jstep("rejump_done", 0, 0, 1, 0, 0, 32'h4000);
    jstep("hj_a", 1, 1, 0, 0, 1, 32'h4000);
    jstep("hj_b", 0, 1, 0, 0, 1, 32'h4000);
    jstep("hj_hold", 0, 1, 0, 1, 0, 32'h4000);
    jstep("hj_release", 0, 0, 0, 1, 0, 32'h4000);
    jstep("hj_run", 0, 0, 1, 0, 0, 32'h4000);
    jstep("hold_run", 0, 1, 0, 1, 0, 32'h4000);
    jstep("hold_state", 0, 1, 0, 1, 0, 32'h4000);
    jstep("hold_exit", 0, 0, 0, 1, 0, 32'h4000);
    jstep("hold_done", 0, 0, 1, 0, 0, 32'h4000);

    @(negedge clk);
    drive(1, 5'd14, 5'd0, 5'd3, 0, 0, 5'd0, 0, 0);
    #1 chk("pre_reset_stall", 0, 1, 0, 1, 32'h4000);
    #1 rst = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    #1 chk("reset_held", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("after_reset_issue", 1, 0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
